sram_dp_be: RTL and testbench

Parametrised simple dual-port synchronous SRAM (one write port, one read port) with byte-enable writes, selectable read latency, and defined read-during-write behaviour. It also has a post-reset clear sequencer that zeroes the array before declaring itself ready. It is the general-purpose storage primitive for weight and activation buffers. It replaces the plain single-cycle SRAM wherever partial writes, a registered output, or a known post-reset state are required.

---
 rtl/sram_pkg.sv | 42 ++++
 rtl/sram_clear_seq.sv | 59 +++++
 rtl/sram_dp_be.sv | 118 +++++++++++
 tb/tb_sram_dp_be.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enable dual-port SRAM.
// Holds the clear-sequencer state enum, legality checks and the lane-merge function.
package sram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    localparam int MAX_DATA_WIDTH   = 256;
    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 2;

    function automatic bit widthsLegal(input int dataWidth, input int byteWidth);
        return (byteWidth > 0) && (dataWidth > 0) && (dataWidth <= MAX_DATA_WIDTH)
            && ((dataWidth % byteWidth) == 0);
    endfunction

    function automatic bit latencyLegal(input int readLatency);
        return (readLatency >= MIN_READ_LATENCY) && (readLatency <= MAX_READ_LATENCY);
    endfunction

    // Bit i takes the new value when the lane that owns it is enabled.
    function automatic logic [MAX_DATA_WIDTH-1:0] laneMerge(
        input logic [MAX_DATA_WIDTH-1:0] oldWord,
        input logic [MAX_DATA_WIDTH-1:0] newWord,
        input logic [MAX_DATA_WIDTH-1:0] be,
        input int                        byteWidth
    );
        logic [MAX_DATA_WIDTH-1:0] result;
        result = oldWord;
        if (byteWidth > 0) begin
            for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
                if (be[i / byteWidth]) begin
                    result[i] = newWord[i];
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every address writing zero, then reports ready.
// With CLEAR_ON_RESET=0 it comes out of reset already idle.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_ready
);

    localparam clr_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    clr_state_t            r_state;
    clr_state_t            w_nextState;
    logic [ADDR_WIDTH-1:0] r_clrAddr;
    logic [ADDR_WIDTH-1:0] w_nextAddr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RESET_STATE;
            r_clrAddr <= '0;
        end else begin
            r_state   <= w_nextState;
            r_clrAddr <= w_nextAddr;
        end
    end

    // The last address is zeroed on the same edge that moves the FSM to IDLE.
    always_comb begin
        w_nextState = r_state;
        w_nextAddr  = r_clrAddr;
        case (r_state)
            CLEAR: begin
                if (&r_clrAddr) begin
                    w_nextState = IDLE;
                    w_nextAddr  = '0;
                end else begin
                    w_nextAddr = r_clrAddr + 1'b1;
                end
            end
            IDLE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = RESET_STATE;
            end
        endcase
    end

    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_clrAddr;
    assign o_ready    = (r_state == IDLE);

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte-enable writes, 1- or 2-cycle registered reads,
// selectable read-during-write result and an optional post-reset zeroing pass.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_NEW        = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = "",
    localparam int NUM_LANES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_LANES-1:0]  wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!widthsLegal(DATA_WIDTH, BYTE_WIDTH)) begin : g_badWidth
        $error("sram_dp_be: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
    end
    if (!latencyLegal(READ_LATENCY)) begin : g_badLatency
        $error("sram_dp_be: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_ready;
    logic                  w_clrWe;
    logic [ADDR_WIDTH-1:0] w_clrAddr;
    logic                  w_wrAccept;
    logic                  w_rdAccept;
    logic                  w_rdwHit;
    logic [DATA_WIDTH-1:0] w_wrMerged;
    logic [DATA_WIDTH-1:0] w_rdWord;
    logic                  r_rdValid1;
    logic [DATA_WIDTH-1:0] r_rdData1;

    sram_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clearSeq (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .o_clr_we   (w_clrWe),
        .o_clr_addr (w_clrAddr),
        .o_ready    (w_ready)
    );

    assign ready      = w_ready;
    assign w_wrAccept = w_ready & wr_en;
    assign w_rdAccept = w_ready & rd_en;
    assign w_rdwHit   = w_wrAccept && (wr_addr == rd_addr);

    assign w_wrMerged = DATA_WIDTH'(laneMerge(MAX_DATA_WIDTH'(r_mem[wr_addr]),
                                              MAX_DATA_WIDTH'(wr_data),
                                              MAX_DATA_WIDTH'(wr_be),
                                              BYTE_WIDTH));

    // A same-address read sees the merged word only when RDW_NEW is set.
    assign w_rdWord = ((RDW_NEW != 0) && w_rdwHit) ? w_wrMerged : r_mem[rd_addr];

    // Storage is deliberately unreset; only the clear pass zeroes it.
    always_ff @(posedge clk) begin
        if (w_clrWe) begin
            r_mem[w_clrAddr] <= '0;
        end else if (w_wrAccept) begin
            r_mem[wr_addr] <= w_wrMerged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdValid1 <= 1'b0;
            r_rdData1  <= '0;
        end else begin
            r_rdValid1 <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdData1 <= w_rdWord;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_rdValid2;
        logic [DATA_WIDTH-1:0] r_rdData2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdValid2 <= 1'b0;
                r_rdData2  <= '0;
            end else begin
                r_rdValid2 <= r_rdValid1;
                if (r_rdValid1) begin
                    r_rdData2 <= r_rdData1;
                end
            end
        end

        assign rd_valid = r_rdValid2;
        assign rd_data  = r_rdData2;
    end else begin : g_lat1
        assign rd_valid = r_rdValid1;
        assign rd_data  = r_rdData1;
    end

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: a default instance (latency 1, old-data RDW)
// and an alternate instance (latency 2, new-data RDW) share all inputs.
module tb_sram_dp_be;

    logic        clk;
    logic        rst_n;
    logic        wrEn;
    logic [7:0]  wrAddr;
    logic [1:0]  wrBe;
    logic [15:0] wrData;
    logic        rdEn;
    logic [7:0]  rdAddr;

    logic        readyDef;
    logic [15:0] rdDataDef;
    logic        rdValidDef;
    logic        readyAlt;
    logic [15:0] rdDataAlt;
    logic        rdValidAlt;

    int checks = 0;
    int errors = 0;

    sram_dp_be u_dutDef (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (readyDef),
        .wr_en    (wrEn),
        .wr_addr  (wrAddr),
        .wr_be    (wrBe),
        .wr_data  (wrData),
        .rd_en    (rdEn),
        .rd_addr  (rdAddr),
        .rd_data  (rdDataDef),
        .rd_valid (rdValidDef)
    );

    sram_dp_be #(
        .READ_LATENCY (2),
        .RDW_NEW      (1)
    ) u_dutAlt (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (readyAlt),
        .wr_en    (wrEn),
        .wr_addr  (wrAddr),
        .wr_be    (wrBe),
        .wr_data  (wrData),
        .rd_en    (rdEn),
        .rd_addr  (rdAddr),
        .rd_data  (rdDataAlt),
        .rd_valid (rdValidAlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write cycle; returns at the falling edge after the write edge.
    task automatic doWrite(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] be);
        @(negedge clk);
        wrEn   = 1'b1;
        wrAddr = addr;
        wrData = data;
        wrBe   = be;
        @(negedge clk);
        wrEn = 1'b0;
        wrBe = 2'b00;
    endtask

    // Drives one read cycle; on return the latency-1 result is visible.
    task automatic doRead(input logic [7:0] addr);
        @(negedge clk);
        rdEn   = 1'b1;
        rdAddr = addr;
        @(negedge clk);
        rdEn = 1'b0;
    endtask

    // Counts rising edges until the default instance reports ready (bounded).
    task automatic waitReady(output int cycles);
        cycles = 0;
        while (!readyDef && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (readyDef !== 1'b0 || rdValidDef !== 1'b0 || rdDataDef !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_def: ready=%b valid=%b data=%h expected 0 0 0000",
                     readyDef, rdValidDef, rdDataDef);
        end
        checks++;
        if (readyAlt !== 1'b0 || rdValidAlt !== 1'b0 || rdDataAlt !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_alt: ready=%b valid=%b data=%h expected 0 0 0000",
                     readyAlt, rdValidAlt, rdDataAlt);
        end
        rst_n = 1'b1;
        waitReady(n);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("[TB] FAIL clear_length: ready after %0d edges, expected 256", n);
        end
        checks++;
        if (readyAlt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_alt_ready: ready=%b expected 1", readyAlt);
        end
    endtask

    task automatic test_clear_readback;
        doRead(8'h00);
        checks++;
        if (rdValidDef !== 1'b1 || rdDataDef !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL readback_00: valid=%b data=%h expected 1 0000", rdValidDef, rdDataDef);
        end
        checks++;
        if (rdValidAlt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alt_latency_early: valid=%b expected 0", rdValidAlt);
        end
        @(negedge clk);
        checks++;
        if (rdValidAlt !== 1'b1 || rdDataAlt !== 16'h0000 || rdValidDef !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alt_readback_00: alt valid=%b data=%h def valid=%b expected 1 0000 0",
                     rdValidAlt, rdDataAlt, rdValidDef);
        end
        doRead(8'hFF);
        checks++;
        if (rdValidDef !== 1'b1 || rdDataDef !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL readback_ff: valid=%b data=%h expected 1 0000", rdValidDef, rdDataDef);
        end
    endtask

    task automatic test_byte_enable;
        doWrite(8'h10, 16'hABCD, 2'b11);
        doWrite(8'h10, 16'h1234, 2'b01);
        doRead(8'h10);
        checks++;
        if (rdValidDef !== 1'b1 || rdDataDef !== 16'hAB34) begin
            errors++;
            $display("[TB] FAIL byte_merge: valid=%b data=%h expected 1 ab34", rdValidDef, rdDataDef);
        end
        @(negedge clk);
        checks++;
        if (rdValidAlt !== 1'b1 || rdDataAlt !== 16'hAB34) begin
            errors++;
            $display("[TB] FAIL byte_merge_alt: valid=%b data=%h expected 1 ab34", rdValidAlt, rdDataAlt);
        end
        doWrite(8'h10, 16'hFFFF, 2'b00);
        doRead(8'h10);
        checks++;
        if (rdDataDef !== 16'hAB34) begin
            errors++;
            $display("[TB] FAIL be_zero_noop: data=%h expected ab34", rdDataDef);
        end
        checks++;
        if (rdValidDef !== 1'b1) begin
            errors++;
            $display("[TB] FAIL be_zero_valid: valid=%b expected 1", rdValidDef);
        end
    endtask

    task automatic test_rdw;
        @(negedge clk);
        wrEn   = 1'b1;
        wrAddr = 8'h20;
        wrData = 16'h5555;
        wrBe   = 2'b11;
        rdEn   = 1'b1;
        rdAddr = 8'h20;
        @(negedge clk);
        wrEn = 1'b0;
        wrBe = 2'b00;
        rdEn = 1'b0;
        checks++;
        if (rdValidDef !== 1'b1 || rdDataDef !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL rdw_old: valid=%b data=%h expected 1 0000", rdValidDef, rdDataDef);
        end
        @(negedge clk);
        checks++;
        if (rdValidAlt !== 1'b1 || rdDataAlt !== 16'h5555) begin
            errors++;
            $display("[TB] FAIL rdw_new: valid=%b data=%h expected 1 5555", rdValidAlt, rdDataAlt);
        end
        doRead(8'h20);
        checks++;
        if (rdValidDef !== 1'b1 || rdDataDef !== 16'h5555) begin
            errors++;
            $display("[TB] FAIL rdw_after: valid=%b data=%h expected 1 5555", rdValidDef, rdDataDef);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] expData;
        for (int i = 0; i < 4; i++) begin
            doWrite(8'(i), 16'h1000 + 16'(i), 2'b11);
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            rdEn   = (cyc < 4);
            rdAddr = 8'(cyc);
            @(negedge clk);
            checks++;
            expData = 16'h1000 + 16'(cyc);
            if (rdValidDef !== (cyc < 4) || ((cyc < 4) && rdDataDef !== expData)) begin
                errors++;
                $display("[TB] FAIL b2b_def cyc%0d: valid=%b data=%h expected %b %h",
                         cyc, rdValidDef, rdDataDef, (cyc < 4), expData);
            end
            checks++;
            expData = 16'h1000 + 16'(cyc) - 16'h0001;
            if (rdValidAlt !== (cyc >= 1 && cyc <= 4)
                || ((cyc >= 1 && cyc <= 4) && rdDataAlt !== expData)) begin
                errors++;
                $display("[TB] FAIL b2b_alt cyc%0d: valid=%b data=%h expected %b %h",
                         cyc, rdValidAlt, rdDataAlt, (cyc >= 1 && cyc <= 4), expData);
            end
        end
        rdEn = 1'b0;
    endtask

    task automatic test_ignore_during_clear;
        int n;
        bit sawValid;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        wrEn   = 1'b1;
        wrAddr = 8'h05;
        wrData = 16'hBEEF;
        wrBe   = 2'b11;
        rdEn   = 1'b1;
        rdAddr = 8'h05;
        @(negedge clk);
        wrEn = 1'b0;
        wrBe = 2'b00;
        rdEn = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rdValidDef || rdValidAlt) sawValid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (sawValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_ignore_read: rd_valid seen=%b expected 0", sawValid);
        end
        waitReady(n);
        checks++;
        if (readyDef !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_ignore_ready: ready=%b after %0d edges expected 1", readyDef, n);
        end
        doRead(8'h05);
        checks++;
        if (rdValidDef !== 1'b1 || rdDataDef !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL clear_ignore_write: valid=%b data=%h expected 1 0000", rdValidDef, rdDataDef);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        rdEn   = 1'b1;
        rdAddr = 8'h00;
        @(negedge clk);
        rdEn  = 1'b0;
        rst_n = 1'b1;
        waitReady(n);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("[TB] FAIL clear_restart: ready after %0d edges, expected 256", n);
        end
        doRead(8'h00);
        checks++;
        if (rdValidDef !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_setup: valid=%b expected 1", rdValidDef);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdValidDef !== 1'b0 || readyDef !== 1'b0 || rdValidAlt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_async: def valid=%b ready=%b alt valid=%b expected 0 0 0",
                     rdValidDef, readyDef, rdValidAlt);
        end
        @(negedge clk);
        checks++;
        if (rdValidAlt !== 1'b0 || rdDataAlt !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL flush_pipe: alt valid=%b data=%h expected 0 0000", rdValidAlt, rdDataAlt);
        end
        rst_n = 1'b1;
        waitReady(n);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("[TB] FAIL flush_recover: ready after %0d edges, expected 256", n);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrBe   = '0;
        wrData = '0;
        rdEn   = 1'b0;
        rdAddr = '0;
        #1;
        test_reset();
        test_clear_readback();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_ignore_during_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
